// File: rtl/serial_adder_pkg.sv
// Shared types for the digit-serial adder/subtractor core.
// FSM state encoding and add/sub operation codes.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_core_fa_slice.sv
// Combinational DIGIT-bit ripple adder used once per RUN cycle.
// c_msb_in is the carry entering the top bit, used for signed overflow.
module fa_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic c;

  always_comb begin
    c        = ci;
    c_msb_in = ci;
    s        = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder_core.sv
// Digit-serial add/subtract core, DIGIT bits per cycle, valid/ready both sides.
// Define SERIAL_ADDER_OVF_EN to build the signed overflow flag.
module serial_adder_core
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_cfg
      $error("serial_adder_core: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             cout_q, cout_d;

  logic [DIGIT-1:0] s_dig;
  logic             co;
  logic             c_msb;
  logic             last;

  fa_slice #(.DIGIT(DIGIT)) u_fa (
    .x        (a_q[DIGIT-1:0]),
    .y        (b_q[DIGIT-1:0]),
    .ci       (carry_q),
    .s        (s_dig),
    .co       (co),
    .c_msb_in (c_msb)
  );

  assign last      = (cnt_q == CW'(NDIG - 1));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtract runs as a + ~b + ~cin, so the final carry is an inverted borrow.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    cout_d  = cout_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = a;
      b_d     = (sub == OP_ADD) ? b : ~b;
      carry_d = (sub == OP_ADD) ? cin : ~cin;
      sub_d   = sub;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      sum_d   = (sum_q >> DIGIT) | (WIDTH'(s_dig) << (WIDTH - DIGIT));
      carry_d = co;
      cnt_d   = cnt_q + CW'(1);
      if (last) cout_d = co ^ (sub_q == OP_SUB);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst)                        ovf_q <= 1'b0;
    else if (state_q == RUN && last) ovf_q <= c_msb ^ co;
  end

  assign ovf = ovf_q;
`else
  logic ovf_unused;

  assign ovf_unused = c_msb;
  assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_core.sv
// Directed and random checks of serial_adder_core at DIGIT = 1, 4 and 16.
// Honours SERIAL_ADDER_OVF_EN when predicting the overflow flag.
module tb_serial_adder_core;

`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  localparam int DG [3]  = '{1, 4, 16};
  localparam int LAT [3] = '{16, 4, 1};

  logic        clk = 1'b0;
  logic        rst, in_valid, cin, sub, ordy;
  logic [15:0] a, b;

  logic        ir [3];
  logic        ov [3];
  logic [15:0] sw [3];
  logic        cw [3];
  logic        fw [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_core #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[0]), .out_ready(1'b1),
    .sum(sw[0]), .cout(cw[0]), .ovf(fw[0])
  );

  serial_adder_core #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[1]), .out_ready(ordy),
    .sum(sw[1]), .cout(cw[1]), .ovf(fw[1])
  );

  serial_adder_core #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[2]), .out_ready(1'b1),
    .sum(sw[2]), .cout(cw[2]), .ovf(fw[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Exact arithmetic reference: {ovf, cout, sum}
  function automatic logic [17:0] model(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic ci, input logic sb);
    int ux, uy, sx, sy, u, s;
    logic c;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!sb) begin
      u = ux + uy + int'(ci);
      s = sx + sy + int'(ci);
      c = (u > 65535);
    end else begin
      u = ux - uy - int'(ci);
      s = sx - sy - int'(ci);
      c = (u < 0);
    end
    return {OVF_EN && (s > 32767 || s < -32768), c, u[15:0]};
  endfunction

  task automatic start(input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic sb);
    int n = 0;
    @(negedge clk);
    while (!(ir[0] && ir[1] && ir[2]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {29'd0, ir[0], ir[1], ir[2]}, 32'd7);
    a        = av;
    b        = bv;
    cin      = ci;
    sub      = sb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    cin      = 1'($urandom);
    sub      = 1'($urandom);
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb,
                        input logic [15:0] es, input logic ec,
                        input logic eo);
    int          lat [3];
    logic [15:0] rs [3];
    logic        rc [3];
    logic        ro [3];
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1;
      rs[i]  = 'x;
      rc[i]  = 1'bx;
      ro[i]  = 1'bx;
    end
    start(av, bv, ci, sb);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (lat[i] < 0 && ov[i]) begin
          lat[i] = k;
          rs[i]  = sw[i];
          rc[i]  = cw[i];
          ro[i]  = fw[i];
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sum_d%0d %h,%h,%b,%b", DG[i], av, bv, ci, sb),
          {16'd0, rs[i]}, {16'd0, es});
      chk($sformatf("cout_d%0d", DG[i]), {31'd0, rc[i]}, {31'd0, ec});
      chk($sformatf("ovf_d%0d", DG[i]), {31'd0, ro[i]}, {31'd0, eo});
      chk($sformatf("lat_d%0d", DG[i]), lat[i], LAT[i]);
    end
  endtask

  initial begin
    logic [17:0] m;
    logic [15:0] ra, rb;
    logic        rci, rsb;
    int          n;

    rst      = 1'b1;
    in_valid = 1'b0;
    ordy     = 1'b1;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    sub      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, ir[1]}, 32'd1);
    chk("rst_out_valid", {31'd0, ov[1]}, 32'd0);
    chk("rst_sum", {16'd0, sw[1]}, 32'd0);
    chk("rst_cout", {31'd0, cw[1]}, 32'd0);
    chk("rst_ovf", {31'd0, fw[1]}, 32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_EN);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, OVF_EN);
    run_op(16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b0, 1'b0);
    run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Hold the DIGIT=4 result under backpressure
    ordy = 1'b0;
    start(16'h1111, 16'h2222, 1'b0, 1'b0);
    n = 0;
    while (!ov[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", {31'd0, ov[1]}, 32'd1);
    chk("bp_sum", {16'd0, sw[1]}, 32'h3333);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_stable", {16'd0, sw[1]}, 32'h3333);
      chk("bp_in_ready", {31'd0, ir[1]}, 32'd0);
      chk("bp_out_valid", {31'd0, ov[1]}, 32'd1);
    end
    ordy = 1'b1;
    @(negedge clk);
    chk("bp_release", {30'd0, ir[1], ov[1]}, 32'd2);

    // Reset during RUN abandons the operation
    start(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", {29'd0, ir[0], ir[1], ir[2]}, 32'd7);
    chk("mid_rst_valid", {31'd0, ov[1]}, 32'd0);
    chk("mid_rst_sum", {16'd0, sw[1]}, 32'd0);
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

    for (int t = 0; t < 1000; t++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rci = 1'($urandom);
      rsb = 1'($urandom);
      m   = model(ra, rb, rci, rsb);
      run_op(ra, rb, rci, rsb, m[15:0], m[16], m[17]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
